// File: rtl/microwave_pkg.sv
// ============================================================================
// microwave_pkg : timer states, BCD time type and BCD time arithmetic helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } timer_state_e;

  // [3]=minutes tens, [2]=minutes units, [1]=seconds tens, [0]=seconds units
  typedef logic [3:0][3:0] bcd_time_t;

  localparam logic [3:0]  c_sec_tens_max = 4'd5;
  localparam logic [15:0] c_time_sat     = 16'h9959;

  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t[0] != 4'd0) begin
      r[0] = t[0] - 4'd1;
    end else begin
      r[0] = 4'd9;
      if (t[1] != 4'd0) begin
        r[1] = t[1] - 4'd1;
      end else begin
        r[1] = c_sec_tens_max;
        if (t[2] != 4'd0) begin
          r[2] = t[2] - 4'd1;
        end else begin
          r[2] = 4'd9;
          r[3] = t[3] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Seconds tens >= 3 carries a minute; entered 60-99 seconds stay above 59.
  function automatic bcd_time_t bcd_add30(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t[1] < 4'd3) begin
      r[1] = t[1] + 4'd3;
    end else begin
      r[1] = t[1] - 4'd3;
      if (t[3:2] == 8'h99) begin
        r = bcd_time_t'(c_time_sat);
      end else if (t[2] == 4'd9) begin
        r[2] = 4'd0;
        r[3] = t[3] + 4'd1;
      end else begin
        r[2] = t[2] + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cook_timer_if.sv
// ============================================================================
// cook_timer_if : keypad / heat inputs and display / status outputs.
// Optional add30 strobe present when COOK_TIMER_ADD30_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cook_timer_if;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        clear;
  logic        heat;
`ifdef COOK_TIMER_ADD30_EN
  logic        add30;
`endif
  logic        finish;
  logic        running;
  logic [15:0] time_bcd;

`ifdef COOK_TIMER_ADD30_EN
  modport master (output key_valid, key_digit, clear, heat, add30,
                  input  finish, running, time_bcd);
  modport slave  (input  key_valid, key_digit, clear, heat, add30,
                  output finish, running, time_bcd);
`else
  modport master (output key_valid, key_digit, clear, heat,
                  input  finish, running, time_bcd);
  modport slave  (input  key_valid, key_digit, clear, heat,
                  output finish, running, time_bcd);
`endif
endinterface

`default_nettype wire

// File: rtl/cook_timer_tick_gen.sv
// ============================================================================
// tick_gen : one-cycle tick every CLK_HZ enabled cycles; count held while en=0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int CLK_HZ = 1000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             c_w   = $clog2(CLK_HZ);
  localparam logic [c_w-1:0] c_max = c_w'(CLK_HZ - 1);

  logic [c_w-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == c_max) begin
        count_d = '0;
        tick    = 1'b1;
      end else begin
        count_d = count_q + c_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/cook_timer.sv
// ============================================================================
// cook_timer : BCD MM:SS countdown gated by heat, one-cycle finish at 00:00.
// Optional macro COOK_TIMER_ADD30_EN adds the +30 s strobe.  Revision: 1.0
// ============================================================================
`default_nettype none

module cook_timer
  import microwave_pkg::*;
#(
  parameter int CLK_HZ = 1000
) (
  input  logic         clk,
  input  logic         nrst,
  cook_timer_if.slave  bus
);

  timer_state_e state_q, state_d;
  bcd_time_t    time_q, time_d;
  logic         tick, pre_en, pre_clr, add30;

`ifdef COOK_TIMER_ADD30_EN
  assign add30 = bus.add30;
`else
  assign add30 = 1'b0;
`endif

  // Prescaler only advances while actually heating; it restarts from 0 on every IDLE->RUN.
  assign pre_en  = (state_q == ST_RUN) && bus.heat;
  assign pre_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .nrst (nrst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.heat) begin
          state_d = (time_q == '0) ? ST_DONE : ST_RUN;
        end else if (add30) begin
          time_d = bcd_add30(time_q);
        end else if (bus.clear) begin
          time_d = '0;
        end else if (bus.key_valid && (bus.key_digit <= 4'd9)) begin
          time_d = {time_q[2:0], bus.key_digit};
        end
      end
      ST_RUN: begin
        time_d = tick ? bcd_dec(time_q) : time_q;
        if (!bus.heat) state_d = ST_HOLD;
        if (tick && (time_d == '0)) begin
          state_d = ST_DONE;
        end else if (add30) begin
          time_d = bcd_add30(time_d);
        end
      end
      ST_HOLD: begin
        if (bus.heat) begin
          state_d = ST_RUN;
        end else if (bus.clear) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end
        if (add30 && (state_d != ST_IDLE)) time_d = bcd_add30(time_q);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        time_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
    end
  end

  assign bus.finish   = (state_q == ST_DONE);
  assign bus.running  = (state_q == ST_RUN);
  assign bus.time_bcd = time_q;

endmodule

`default_nettype wire

// File: doc/cook_timer.md
# cook_timer

Countdown timer that sits upstream of the microwave controller and generates its `finish` input. The user enters a MM:SS cook time as BCD keypad digits. The timer counts down once per second while the controller's `heat` output is high, and holds its value while `heat` is low. When the count reaches 00:00 it issues a one-cycle `finish` pulse.

## Interface
- CLK_HZ, 1000: clk cycles per one-second tick; minimum 2.
- clk  in  1  system clock
- nrst  in  1  reset nrst, asynchronous, active-low; clock clk
- key_valid  in  1  one-cycle strobe, `key_digit` is valid
- key_digit  in  4  BCD digit 0–9; values 10–15 are ignored
- clear  in  1  one-cycle strobe, zero the entered/held time
- heat  in  1  magnetron-on indication from the microwave controller
- finish  out  1  one-cycle pulse, cook time elapsed
- running  out  1  high in RUN
- time_bcd  out  16  {M tens, M units, S tens, S units}, BCD, for the display

## Operation
- States: IDLE, RUN, HOLD, DONE. Reset: IDLE, time_bcd=16'h0000, finish=0, running=0, prescaler=0.
- IDLE:
  - key_valid with digit ≤9: time_bcd <= {time_bcd[11:0], key_digit}. The leading digit is lost.
  - clear: time_bcd <= 0.
  - heat=1 and time≠0: go to RUN.
  - heat=1 and time=0: go to DONE.
  - heat has priority over key_valid/clear in the same cycle.
- RUN:
  - The prescaler counts 0..CLK_HZ-1. A tick fires on wrap.
  - On each tick, decrement time by one second:
    - S units borrow 0→9.
    - S tens borrow 0→5.
    - SS=00 with MM>0 gives SS=59 and MM-1.
  - Entered seconds 60–99 are kept and decremented as-is (e.g. 00:90 → 00:89).
  - A tick that yields 00:00 goes to DONE.
  - heat=0 goes to HOLD. The prescaler value is retained.
  - Keys and clear are ignored.
- HOLD:
  - heat=1: back to RUN, prescaler continues from its held value.
  - clear: go to IDLE, time=0, prescaler=0.
  - Keys are ignored.
- DONE:
  - finish=1 for exactly this one cycle; time_bcd=0.
  - Unconditionally go to IDLE next cycle with prescaler=0.
- Outputs: finish=(state==DONE), running=(state==RUN). Both are registered-state decodes with no input-to-output path.

## Timing
- A key is visible on time_bcd the cycle after the key_valid edge.
- IDLE→RUN occurs on the edge where heat=1 is sampled. The first decrement happens CLK_HZ cycles later.
- Entry at T with N seconds and heat continuously high: finish is asserted in cycle T+N·CLK_HZ+1.
- finish lasts one cycle. The controller leaves COOK on the following edge, so heat is low by the time the timer is back in IDLE and there is no retrigger.
- nrst asserted mid-RUN: immediately IDLE, time=0, finish=0.

## Configuration
- COOK_TIMER_ADD30_EN defined:
  - Adds input port `add30` (1 bit, one-cycle strobe).
  - In IDLE, RUN or HOLD, add 30 s in BCD with carry into minutes; saturate at 99:59.
  - In IDLE with time=0, add30 loads 00:30.
  - add30 has priority over key_valid in the same cycle.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `microwave_pkg`:
  - timer state enum (IDLE, RUN, HOLD, DONE)
  - BCD time typedef (4×4 bits)
  - constants for seconds-tens limit 5 and saturation value 16'h9959
- Sub-module `tick_gen`:
  - Parameters: CLK_HZ.
  - Ports: clk, nrst, en, clr, tick.
  - Holds its count while en=0.

## Test plan
All scenarios use CLK_HZ=4.
- Keys 1,3,0 then heat=1 → time_bcd 16'h0130. After 4 cycles 16'h0129; after 5 more ticks 16'h0124.
- Load 00:02, heat=1 held → finish high for exactly one cycle 8 cycles after RUN entry, then IDLE with time 0.
- Load 01:00, run 1 tick → 16'h0059. Drop heat for 10 cycles → value frozen. Raise heat → resumes with the held prescaler phase.
- heat=1 with time 0 → finish pulse on the next cycle. Key 0x0C → ignored. Keys 1,2,3,4,5 → 16'h2345.
- HOLD at 00:40 plus clear → IDLE, 16'h0000, no finish. nrst pulse mid-RUN → all outputs 0 immediately.
- With COOK_TIMER_ADD30_EN: add30 at 00:45 → 16'h0115; add30 at 99:50 → 16'h9959.
